// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: pixel-enable divider, x/y raster counters,
// and a one-pixel-latency registered output stage for sync, blanking and colour.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [3:0]  ON_LEVEL = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pixel_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       video_on,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] r_div;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic [3:0] r_level;

  logic       w_pe;
  logic       w_x_last;
  logic       w_y_last;
  logic       w_vis;
  logic       w_hs_n;
  logic       w_vs_n;

  assign w_pe     = (r_div == DIV_LAST);
  assign w_x_last = (r_x == H_LAST);
  assign w_y_last = (r_y == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_div <= '0;
    else if (w_pe) r_div <= '0;
    else           r_div <= r_div + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pe) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + 10'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end
  end

  // Decoded from the live counters, then registered on pe so sync and colour
  // both leave one pixel after the x/y that produced them.
  assign w_vis  = (r_x < H_VIS) && (r_y < V_VIS);
  assign w_hs_n = !((r_x >= HS_BEGIN) && (r_x < HS_END));
  assign w_vs_n = !((r_y >= VS_BEGIN) && (r_y < VS_END));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b0;
      r_level    <= '0;
    end else if (w_pe) begin
      r_hsync    <= w_hs_n;
      r_vsync    <= w_vs_n;
      r_video_on <= w_vis;
      r_level    <= (w_vis && pixel_on) ? ON_LEVEL : '0;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign vga_r       = r_level;
  assign vga_g       = r_level;
  assign vga_b       = r_level;
  assign frame_start = w_pe && w_x_last && w_y_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against a
// closed-form raster model, plus literal timing expectations.
module tb_vga_timing_gen;

  typedef struct {
    int unsigned ha, hf, hs, hb, va, vf, vs, vb, d;
    logic [3:0]  on;
    int          pat;
  } cfg_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       fs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } obs_t;

  cfg_t CA = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 4'hF, 0};
  cfg_t CB = '{8, 2, 3, 3, 6, 1, 2, 1, 1, 4'hF, 1};
  cfg_t CC = '{10, 2, 4, 4, 4, 1, 1, 2, 3, 4'hA, 2};

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  function automatic logic pattern(int id, int unsigned px, int unsigned py);
    case (id)
      0:       return (py < 4) || ((px / 32) % 2 == 1);
      1:       return 1'b1;
      default: return ((px + py) % 3) == 0;
    endcase
  endfunction

  // After k clock edges out of reset: k/d pixels have elapsed; outputs show pixel k/d-1.
  function automatic obs_t model(cfg_t c, int unsigned k);
    int unsigned ht, vt, p, q, px, py;
    logic vis;
    logic [3:0] lvl;
    obs_t o;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    p  = k / c.d;
    o.x = 10'(p % ht);
    o.y = 10'((p / ht) % vt);
    if (p == 0) begin
      o.hs = 1'b1; o.vs = 1'b1; o.von = 1'b0; lvl = 4'h0;
    end else begin
      q   = p - 1;
      px  = q % ht;
      py  = (q / ht) % vt;
      vis = (px < c.ha) && (py < c.va);
      o.hs  = !((px >= c.ha + c.hf) && (px < c.ha + c.hf + c.hs));
      o.vs  = !((py >= c.va + c.vf) && (py < c.va + c.vf + c.vs));
      o.von = vis;
      lvl   = (vis && pattern(c.pat, px, py)) ? c.on : 4'h0;
    end
    o.r = lvl; o.g = lvl; o.b = lvl;
    o.fs = ((k % c.d) == c.d - 1) && (o.x == 10'(ht - 1)) && (o.y == 10'(vt - 1));
    return o;
  endfunction

  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic hs_a, vs_a, von_a, fs_a, hs_b, vs_b, von_b, fs_b, hs_c, vs_c, von_c, fs_c;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic pon_a, pon_b, pon_c;
  obs_t ga, gb, gc;

  assign pon_a = pattern(CA.pat, x_a, y_a);
  assign pon_b = pattern(CB.pat, x_b, y_b);
  assign pon_c = pattern(CC.pat, x_c, y_c);
  assign ga = {x_a, y_a, hs_a, vs_a, von_a, fs_a, r_a, g_a, b_a};
  assign gb = {x_b, y_b, hs_b, vs_b, von_b, fs_b, r_b, g_b, b_b};
  assign gc = {x_c, y_c, hs_c, vs_c, von_c, fs_c, r_c, g_c, b_c};

  vga_timing_gen u_a (
    .clk(clk), .rst_n(rst_n), .pixel_on(pon_a), .x(x_a), .y(y_a),
    .hsync(hs_a), .vsync(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
    .video_on(von_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .ON_LEVEL(4'hF)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .pixel_on(pon_b), .x(x_b), .y(y_b),
    .hsync(hs_b), .vsync(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .video_on(von_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(4), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .CLK_DIV(3), .ON_LEVEL(4'hA)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .pixel_on(pon_c), .x(x_c), .y(y_c),
    .hsync(hs_c), .vsync(vs_c), .vga_r(r_c), .vga_g(g_c), .vga_b(b_c),
    .video_on(von_c), .frame_start(fs_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp_obs(string nm, obs_t got, obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t: got %h required %h", nm, $time, got, exp);
    end
  endtask

  task automatic cmp_int(string nm, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  int unsigned k = 0;
  always @(posedge clk) k = rst_n ? k + 1 : 0;

  int a_fall1 = -1, a_fall2 = -1, a_rise1 = -1;
  int b_vfall = -1, b_vrise = -1, b_fs1 = -1, b_fs2 = -1, b_fs_post = -1;
  int c_fs1 = -1, c_fs2 = -1;
  logic after_mid = 1'b0;
  logic p_hs_a = 1'b1, p_vs_b = 1'b1;

  always @(negedge clk) begin
    int unsigned kk;
    kk = rst_n ? k : 0;
    cmp_obs("dut_a", ga, model(CA, kk));
    cmp_obs("dut_b", gb, model(CB, kk));
    cmp_obs("dut_c", gc, model(CC, kk));
    if (rst_n && !after_mid) begin
      if (p_hs_a && !hs_a) begin
        if (a_fall1 < 0) a_fall1 = int'(kk);
        else if (a_fall2 < 0) a_fall2 = int'(kk);
      end
      if (!p_hs_a && hs_a && a_rise1 < 0) a_rise1 = int'(kk);
      if (p_vs_b && !vs_b && b_vfall < 0) b_vfall = int'(kk);
      if (!p_vs_b && vs_b && b_vfall >= 0 && b_vrise < 0) b_vrise = int'(kk);
      if (fs_b) begin
        if (b_fs1 < 0) b_fs1 = int'(kk);
        else if (b_fs2 < 0) b_fs2 = int'(kk);
      end
      if (fs_c) begin
        if (c_fs1 < 0) c_fs1 = int'(kk);
        else if (c_fs2 < 0) c_fs2 = int'(kk);
      end
    end
    if (rst_n && after_mid && fs_b && b_fs_post < 0) b_fs_post = int'(kk);
    p_hs_a = hs_a;
    p_vs_b = vs_b;
  end

  initial begin
    int i;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    repeat (32000) @(posedge clk);

    // Wait for dut_b mid-frame before pulsing reset between edges.
    i = 0;
    while (y_b != 10'd6 && i < 1000) begin
      @(posedge clk);
      i++;
    end
    cmp_int("mid_wait_expired", (i < 1000) ? 1 : 0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp_obs("async_reset_a", ga, model(CA, 0));
    cmp_obs("async_reset_b", gb, model(CB, 0));
    cmp_obs("async_reset_c", gc, model(CC, 0));
    cmp_int("async_reset_lit_b", int'({x_b, y_b, hs_b, vs_b, von_b, fs_b, r_b}), int'({20'd0, 4'b1100, 4'h0}));
    after_mid = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (600) @(posedge clk);

    cmp_int("a_first_hsync_fall", a_fall1, 1314);
    cmp_int("a_hsync_low_width", a_rise1 - a_fall1, 192);
    cmp_int("a_hsync_period", a_fall2 - a_fall1, 1600);
    cmp_int("b_vsync_low_width", b_vrise - b_vfall, 32);
    cmp_int("b_first_frame_start", b_fs1, 159);
    cmp_int("b_frame_spacing", b_fs2 - b_fs1, 160);
    cmp_int("c_first_frame_start", c_fs1, 479);
    cmp_int("c_frame_spacing", c_fs2 - c_fs1, 480);
    cmp_int("b_frame_after_mid_reset", b_fs_post, 159);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
